// File: rtl/adder_arbiter_pkg.sv
// Shared widths and the FSM state encoding for the adder_arbiter block.
// Imported by the arbiter top and by the prefix adder.
package adder_arbiter_pkg;

    localparam int OP_W  = 6;
    localparam int SUM_W = 7;
    localparam int ID_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder.sv
// Team 6-bit Kogge-Stone prefix adder: s = x + y, with the carry-out in s[6].
// Purely combinational.
module adder
    import adder_arbiter_pkg::*;
(
    input  logic [OP_W-1:0]  x,
    input  logic [OP_W-1:0]  y,
    output logic [SUM_W-1:0] s
);

    logic [OP_W-1:0] g;
    logic [OP_W-1:0] p;
    logic [OP_W-1:0] half_sum;
    logic [OP_W-1:0] carry;

    always_comb begin
        half_sum = x ^ y;
        g        = x & y;
        p        = half_sum;
        // Descending bit order inside a stage means g[i-d]/p[i-d] still hold the
        // previous stage's values when bit i combines with them.
        for (int d = 1; d < OP_W; d = d * 2) begin
            for (int i = OP_W - 1; i >= d; i--) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        carry[0] = 1'b0;
        for (int i = 1; i < OP_W; i++) begin
            carry[i] = g[i-1];
        end
        s = {g[OP_W-1], half_sum ^ carry};
    end

endmodule

// File: rtl/adder_arbiter.sv
// Shares one prefix adder between N_REQ requesters using a round-robin grant.
// One operation is in flight at a time: IDLE -> CALC -> RESP -> IDLE.
module adder_arbiter
    import adder_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*OP_W-1:0]   req_x,
    input  logic [N_REQ*OP_W-1:0]   req_y,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [SUM_W-1:0]        rsp_s,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; a valid that drops before that edge leaves no trace.
    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [OP_W-1:0]   x_q;
    logic [OP_W-1:0]   y_q;
    logic [ID_W-1:0]   id_q;
    logic [SUM_W-1:0]  sum;

    logic [ID_W:0]     pick;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    logic [OP_W-1:0]   sel_x;
    logic [OP_W-1:0]   sel_y;
    logic              accept;

    // Returns {found, index}: first valid requester starting after last.
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [ID_W-1:0]  last);
        logic [ID_W:0] res;
        int            idx;
        res = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last) + k) % N_REQ;
            if (!res[ID_W] && valid[idx]) begin
                res = {1'b1, ID_W'(idx)};
            end
        end
        return res;
    endfunction

    always_comb begin
        pick        = rr_pick(req_valid, last_grant);
        grant_found = pick[ID_W];
        grant_idx   = pick[ID_W-1:0];
        accept      = (state == IDLE) && !rst && grant_found;
        req_ready   = '0;
        sel_x       = '0;
        sel_y       = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                req_ready[i] = accept;
                sel_x        = req_x[i*OP_W +: OP_W];
                sel_y        = req_y[i*OP_W +: OP_W];
            end
        end
    end

    adder u_adder (
        .x (x_q),
        .y (y_q),
        .s (sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(N_REQ - 1);
            x_q        <= '0;
            y_q        <= '0;
            id_q       <= '0;
            rsp_valid  <= 1'b0;
            rsp_s      <= '0;
            rsp_id     <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_q        <= sel_x;
                        y_q        <= sel_y;
                        id_q       <= grant_idx;
                        last_grant <= grant_idx;
                        busy       <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    rsp_s     <= sum;
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // rsp_s/rsp_id are only written in CALC, so they hold under backpressure.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_adder_arbiter.sv
// Self-checking bench for adder_arbiter (N_REQ = 2): directed vector table,
// multi-cycle corner sequences and a randomized run against a behavioural model.
module tb_adder_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [11:0] req_x;
    logic [11:0] req_y;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [6:0]  rsp_s;
    logic [1:0]  rsp_id;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];

    adder_arbiter #(.N_REQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    // Full transaction with rsp_ready held high; entered and left at posedge+1.
    task automatic do_op(input string name, input logic [1:0] v,
                         input logic [5:0] x0, input logic [5:0] y0,
                         input logic [5:0] x1, input logic [5:0] y1,
                         input logic [1:0] eid, input logic [6:0] es,
                         output int accept_wait);
        int          lat;
        logic [1:0]  exp_rr;
        req_valid = v;
        req_x     = {x1, x0};
        req_y     = {y1, y0};
        rsp_ready = 1'b1;
        exp_rr    = 2'b00;
        exp_rr[eid] = 1'b1;
        accept_wait = 0;
        @(negedge clk);
        while (req_ready == 2'b00 && accept_wait < 8) begin
            @(negedge clk);
            accept_wait++;
        end
        check({name, "_grant"}, req_ready, exp_rr);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, lat, 2);
        check({name, "_rsp_s"}, rsp_s, es);
        check({name, "_rsp_id"}, rsp_id, eid);
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model / scoreboard ----------------
    int m_last;
    bit m_out;
    int m_acc;

    task automatic model_step(input int cyc);
        logic [1:0] exp_rr;
        logic       exp_rv;
        int         g;
        int         idx;
        exp_rr = 2'b00;
        g = -1;
        if (!m_out) begin
            for (int k = 1; k <= 2; k++) begin
                idx = (m_last + k) % 2;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rr[g] = 1'b1;
        exp_rv = m_out && (cyc - m_acc >= 2);
        check("rand_req_ready", req_ready, exp_rr);
        check("rand_rsp_valid", rsp_valid, exp_rv);
        check("rand_busy", busy, m_out);
        if (rsp_valid && exp_rv && exp_q.size() > 0) begin
            check("rand_rsp_id_s", {rsp_id, rsp_s}, exp_q[0]);
            if (rsp_ready) begin
                void'(exp_q.pop_front());
                m_out = 1'b0;
            end
        end
        if (g >= 0) begin
            exp_q.push_back({2'(g), 7'(int'(req_x[g*6 +: 6]) + int'(req_y[g*6 +: 6]))});
            m_out  = 1'b1;
            m_acc  = cyc;
            m_last = g;
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        string      name;
        logic [1:0] valid;
        logic [5:0] x0, y0, x1, y1;
        logic [1:0] exp_id;
        logic [6:0] exp_s;
    } vec_t;

    vec_t vecs[8];
    int   aw;
    int   ng, nr, prev, gid;
    logic [1:0] hold_id;
    logic [6:0] hold_s;

    initial begin
        rst = 1'b1;
        req_valid = 2'b11;
        req_x = '0;
        req_y = '0;
        rsp_ready = 1'b0;

        // reset state, with requests pending so req_ready gating is visible
        @(posedge clk);
        #1;
        check("reset_req_ready", req_ready, 2'b00);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_rsp_s", rsp_s, 7'd0);
        check("reset_rsp_id", rsp_id, 2'd0);
        check("reset_busy", busy, 1'b0);
        check("reset_state", dbg_state, 2'd0);
        rst = 1'b0;

        // first edge after release accepts; requester 0 has first priority
        do_op("first", 2'b11, 6'd5, 6'd9, 6'd7, 6'd7, 2'd0, 7'd14, aw);
        check("first_accept_wait", aw, 0);

        vecs[0] = '{"single",   2'b01, 6'd5,  6'd9,  6'd0,  6'd0,  2'd0, 7'd14};
        vecs[1] = '{"max_max",  2'b01, 6'd63, 6'd63, 6'd0,  6'd0,  2'd0, 7'd126};
        vecs[2] = '{"carry",    2'b01, 6'd63, 6'd1,  6'd0,  6'd0,  2'd0, 7'd64};
        vecs[3] = '{"zero",     2'b01, 6'd0,  6'd0,  6'd0,  6'd0,  2'd0, 7'd0};
        vecs[4] = '{"req1",     2'b10, 6'd0,  6'd0,  6'd40, 6'd30, 2'd1, 7'd70};
        vecs[5] = '{"rr_to0",   2'b11, 6'd1,  6'd2,  6'd3,  6'd4,  2'd0, 7'd3};
        vecs[6] = '{"rr_to1",   2'b11, 6'd10, 6'd20, 6'd31, 6'd32, 2'd1, 7'd63};
        vecs[7] = '{"req1_max", 2'b10, 6'd0,  6'd0,  6'd63, 6'd63, 2'd1, 7'd126};
        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].name, vecs[i].valid, vecs[i].x0, vecs[i].y0,
                  vecs[i].x1, vecs[i].y1, vecs[i].exp_id, vecs[i].exp_s, aw);
        end

        // backpressure: 10 cycles of rsp_ready=0 while both requesters wait
        req_valid = 2'b10;
        req_x = {6'd17, 6'd0};
        req_y = {6'd20, 6'd0};
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_grant", req_ready, 2'b10);
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        @(negedge clk);
        check("bp_calc_ready", req_ready, 2'b00);
        @(posedge clk);
        #1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_rsp_valid", rsp_valid, 1'b1);
            check("bp_rsp_s", rsp_s, 7'd37);
            check("bp_rsp_id", rsp_id, 2'd1);
            check("bp_req_ready", req_ready, 2'b00);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", rsp_valid, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        @(negedge clk);
        check("bp_after_valid", rsp_valid, 1'b0);
        check("bp_after_busy", busy, 1'b0);
        @(posedge clk);
        #1;

        // reset pulsed while the operation is in CALC
        req_valid = 2'b01;
        req_x = {6'd0, 6'd7};
        req_y = {6'd0, 6'd8};
        @(negedge clk);
        check("midrst_grant", req_ready, 2'b01);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        check("midrst_in_calc", dbg_state, 2'd1);
        rst = 1'b1;
        #1;
        check("midrst_rsp_valid", rsp_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("midrst_no_stale", rsp_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        do_op("midrst_new", 2'b01, 6'd2, 6'd3, 6'd0, 6'd0, 2'd0, 7'd5, aw);

        // contention: both requesters held valid for four operations
        reset_pulse();
        req_valid = 2'b11;
        req_x = {6'd1, 6'd1};
        req_y = {6'd3, 6'd1};
        rsp_ready = 1'b1;
        ng = 0;
        nr = 0;
        prev = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                gid = (req_ready == 2'b10) ? 1 : 0;
                check("cont_grant", gid, ng % 2);
                check("cont_no_repeat", (gid != prev) ? 1 : 0, 1);
                prev = gid;
                ng++;
            end
            if (rsp_valid) begin
                check("cont_rsp_id", rsp_id, nr % 2);
                check("cont_rsp_s", rsp_s, (nr % 2 == 0) ? 2 : 4);
                nr++;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        check("cont_grant_count", ng, 4);
        check("cont_rsp_count", nr, 4);

        // randomized run against the model
        reset_pulse();
        m_last = 1;
        m_out  = 1'b0;
        m_acc  = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 1000; cyc++) begin
            req_valid = 2'($urandom_range(0, 3));
            req_x     = 12'($urandom);
            req_y     = 12'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            model_step(cyc);
            @(posedge clk);
            #1;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        for (int cyc = 1000; cyc < 1006; cyc++) begin
            @(negedge clk);
            model_step(cyc);
            @(posedge clk);
            #1;
        end
        check("rand_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter N_REQ SHALL default to 2 and set the number of requesters sharing the adder (legal range 2..4).
REQ-003 Port clk SHALL be an input, 1 bit wide, and serve as the single rising-edge clock.
REQ-004 Port rst SHALL be an input, 1 bit wide, and serve as the asynchronous active-high reset.
REQ-005 Port req_valid SHALL be an input, N_REQ bits wide; bit i means requester i presents operands.
REQ-006 Port req_ready SHALL be an output, N_REQ bits wide; bit i means requester i's operands are accepted this cycle.
REQ-007 Port req_x SHALL be an input, N_REQ*6 bits wide; slice [6i+5:6i] is requester i's x operand.
REQ-008 Port req_y SHALL be an input, N_REQ*6 bits wide; slice [6i+5:6i] is requester i's y operand.
REQ-009 Port rsp_valid SHALL be an output, 1 bit wide, meaning a result is present.
REQ-010 Port rsp_ready SHALL be an input, 1 bit wide, meaning the consumer accepts the result.
REQ-011 Port rsp_s SHALL be an output, 7 bits wide, carrying the unsigned sum x+y with the carry in bit 6.
REQ-012 Port rsp_id SHALL be an output, 2 bits wide, carrying the index of the requester that owns rsp_s.
REQ-013 Port busy SHALL be an output, 1 bit wide, and SHALL be high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have three states (IDLE, CALC, RESP) and transition as follows: IDLE->CALC on a request handshake; CALC->RESP unconditionally after 1 cycle; RESP->IDLE on rsp_valid&rsp_ready.
REQ-015 In IDLE with any req_valid set, exactly one req_ready bit SHALL be asserted, combinationally, for the granted requester; all req_ready bits SHALL be 0 in CALC and RESP.
REQ-016 The grant SHALL be round-robin: search starts at last_grant+1 modulo N_REQ, and the first set req_valid bit wins.
REQ-017 On a handshake, the block SHALL register the granted requester's x, y and index, and update last_grant.
REQ-018 In CALC, the registered operands SHALL drive the adder, and its 7-bit output SHALL be registered into rsp_s.
REQ-019 Latency SHALL be fixed: a handshake in cycle T SHALL give rsp_valid=1 in cycle T+2.
REQ-020 rsp_s and rsp_id SHALL stay stable while rsp_valid=1 and rsp_ready=0 (backpressure of any length).
REQ-021 No new request SHALL be accepted while a result is pending; peak throughput SHALL be one operation per 3 cycles.
REQ-022 A req_valid that drops before its handshake SHALL have no effect, and no result SHALL be produced for it.
REQ-023 Arithmetic SHALL be unsigned with no saturation: 63+63 SHALL give 126, and carry-out SHALL appear only in rsp_s[6].
REQ-024 When no requester is valid, the block SHALL stay in IDLE, and last_grant SHALL not change.

Reset
REQ-025 Asserting rst SHALL immediately force: state=IDLE, rsp_valid=0, req_ready=0, rsp_s=0, rsp_id=0, busy=0, last_grant=N_REQ-1 (so requester 0 has first priority).
REQ-026 Reset asserted during CALC or RESP SHALL discard the in-flight operation, and no response for it SHALL appear after reset release.
REQ-027 The first request SHALL be accepted in the first clock edge after rst deasserts.

Structure
REQ-028 Package adder_arbiter_pkg SHALL hold OP_W=6, SUM_W=7, ID_W=2 and the state enum {IDLE, CALC, RESP}.
REQ-029 The block SHALL instantiate exactly one sub-module, the team's 6-bit prefix adder named adder (x[5:0], y[5:0] -> s[6:0]); it SHALL not re-implement the sum.
REQ-030 The round-robin pick SHALL be a function or always block inside adder_arbiter, not a separate module.

Verification
REQ-031 Single request: rst released, req_valid=01, x0=5, y0=9, rsp_ready=1 -> req_ready=01 at T, rsp_valid at T+2, rsp_s=14, rsp_id=0.
REQ-032 Overflow/carry: x=63, y=63 -> rsp_s=126; x=63, y=1 -> rsp_s=64; x=0, y=0 -> rsp_s=0.
REQ-033 Contention: req_valid=11 held for 4 operations -> grants in order 0,1,0,1; rsp_id follows the same order; no requester is accepted twice in a row.
REQ-034 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_s and rsp_id held stable, req_ready=00 throughout; one transfer occurs when rsp_ready=1.
REQ-035 Reset mid-op: rst pulsed in CALC -> the next cycle shows rsp_valid=0 and busy=0, no stale response follows, and a new request x=2, y=3 returns 5.
REQ-036 Random: 1000 random x/y/valid/rsp_ready cycles against a reference model -> every accepted request yields exactly one response with the correct sum and id, in acceptance order.
